// File: rtl/microwave_pkg.sv
// Shared microwave datapath types and 7-segment / digit-enable constants.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package microwave_pkg;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [3:0] time_bcd_t;   // [3]=min_tens .. [0]=sec_ones

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF = 4'b1111;

   // Active-low one-hot enable for scan position idx.
   function automatic logic [3:0] an_select(input logic [1:0] idx);
      return AN_OFF & ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment map; non-BCD codes blank the digit.
module seg7_decode
   import microwave_pkg::*;
(
   input  bcd_t       bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/digit_display_decoder.sv
// Keypad-side cook-time entry: shifts strobed BCD digits into an MM:SS register,
// flags bad digits, and scans the entered time onto a 4-digit 7-segment display.
module digit_display_decoder
   import microwave_pkg::*;
#(
   parameter int SCAN_DIV = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [3:0]  D,
   input  logic        loadn,
   input  logic        Clearn,
   output logic [15:0] Digits,
   output logic        TimeValid,
   output logic        Error,
   output logic [6:0]  Seg,
   output logic [3:0]  An
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic             loadn_q;
   time_bcd_t        digits_q,   digits_d;
   logic             error_q,    error_d;
   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       index_q,    index_d;
   logic [6:0]       seg_q,      seg_d;
   logic [3:0]       an_q,       an_d;

   logic             accept;
   logic             blank;
   logic [6:0]       seg_raw;

   // One digit per falling edge of loadn, however long the strobe is held.
   assign accept = !loadn && loadn_q;

   always_comb begin
      digits_d = digits_q;
      error_d  = error_q;
      if (!Clearn) begin
         digits_d = '0;
         error_d  = 1'b0;
      end else if (accept) begin
         if (D <= 4'd9) digits_d = {digits_q[2:0], D};
         else           error_d  = 1'b1;
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      index_d    = index_q;
      if (scan_cnt_q == CNT_LAST) begin
         scan_cnt_d = '0;
         index_d    = index_q + 2'd1;
      end
   end

   seg7_decode u_seg7_decode (
      .bcd (digits_q[index_q]),
      .seg (seg_raw)
   );

   always_comb begin
      blank = (BLANK_LZ != 0) && (index_q == 2'd3) && (digits_q[3] == 4'd0);
      seg_d = blank ? SEG_BLANK : seg_raw;
      an_d  = an_select(index_q);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         loadn_q    <= 1'b1;
         digits_q   <= '0;
         error_q    <= 1'b0;
         scan_cnt_q <= '0;
         index_q    <= 2'd0;
         seg_q      <= SEG_0;
         an_q       <= 4'b1110;
      end else begin
         loadn_q    <= loadn;
         digits_q   <= digits_d;
         error_q    <= error_d;
         scan_cnt_q <= scan_cnt_d;
         index_q    <= index_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign Digits    = digits_q;
   assign TimeValid = (digits_q != '0) && (digits_q[1] <= 4'd5);
   assign Error     = error_q;
   assign Seg       = seg_q;
   assign An        = an_q;

endmodule

// File: tb/tb_digit_display_decoder.sv
// Directed bench for digit_display_decoder: entry, strobe edge detect, error,
// clear priority and display scan with leading-zero blanking.
module tb_digit_display_decoder;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [3:0]  D = 4'd0;
   logic        loadn = 1'b1;
   logic        Clearn = 1'b1;
   logic [15:0] Digits;
   logic        TimeValid;
   logic        Error;
   logic [6:0]  Seg;
   logic [3:0]  An;

   int n_checks = 0;
   int n_pass   = 0;

   digit_display_decoder #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .D         (D),
      .loadn     (loadn),
      .Clearn    (Clearn),
      .Digits    (Digits),
      .TimeValid (TimeValid),
      .Error     (Error),
      .Seg       (Seg),
      .An        (An)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic enter_digit(input logic [3:0] d);
      @(negedge Clk); D = d; loadn = 1'b0;
      @(negedge Clk); loadn = 1'b1;
      @(negedge Clk);
   endtask

   task automatic clear_time();
      @(negedge Clk); Clearn = 1'b0;
      @(negedge Clk); Clearn = 1'b1;
   endtask

   // Align to the first cycle of scan position 0, then check 16 cycles of scan.
   task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      logic [3:0] prev;
      logic       found;
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an;
      exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         prev = An;
         @(negedge Clk);
         if (prev == 4'b0111 && An == 4'b1110) found = 1'b1;
      end
      check({tag, "_sync"}, {15'd0, found}, 16'd1);
      if (found) begin
         for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge Clk);
            exp_an = 4'b1111 & ~(4'b0001 << (i / 4));
            check($sformatf("%s_c%0d_an_seg", tag, i), {5'd0, An, Seg},
                  {5'd0, exp_an, exp_seg[i / 4]});
         end
      end
   endtask

   initial begin
      // 1. reset
      @(negedge Clk); @(negedge Clk);
      Rst = 1'b0;
      check("rst_digits", Digits, 16'h0000);
      check("rst_valid",  {15'd0, TimeValid}, 16'd0);
      check("rst_error",  {15'd0, Error}, 16'd0);
      check("rst_an",     {12'd0, An}, 16'h000E);
      check("rst_seg",    {9'd0, Seg}, 16'h0040);

      // 2. single-cycle strobes
      enter_digit(4'd1); check("e1", Digits, 16'h0001);
      enter_digit(4'd2);
      enter_digit(4'd3);
      enter_digit(4'd0);
      check("e1230_digits", Digits, 16'h1230);
      check("e1230_valid",  {15'd0, TimeValid}, 16'd1);

      // 3. held strobe enters one digit
      clear_time();
      check("clr_digits", Digits, 16'h0000);
      @(negedge Clk); D = 4'd7; loadn = 1'b0;
      repeat (5) @(negedge Clk);
      loadn = 1'b1;
      @(negedge Clk);
      check("held_digits", Digits, 16'h0007);

      // 4. invalid seconds, then overflow drops oldest digit
      clear_time();
      enter_digit(4'd9); enter_digit(4'd9);
      check("e99_digits", Digits, 16'h0099);
      check("e99_valid",  {15'd0, TimeValid}, 16'd0);
      for (int i = 1; i <= 5; i++) enter_digit(4'(i));
      check("e2345_digits", Digits, 16'h2345);
      check("e2345_valid",  {15'd0, TimeValid}, 16'd1);

      // 5. bad digit sets sticky error; clear beats a same-cycle strobe
      enter_digit(4'hC);
      check("bad_digits", Digits, 16'h2345);
      check("bad_error",  {15'd0, Error}, 16'd1);
      enter_digit(4'd1);
      check("sticky_digits", Digits, 16'h3451);
      check("sticky_error",  {15'd0, Error}, 16'd1);
      @(negedge Clk); D = 4'd5; loadn = 1'b0; Clearn = 1'b0;
      @(negedge Clk); Clearn = 1'b1;
      repeat (3) @(negedge Clk);
      loadn = 1'b1;
      repeat (2) @(negedge Clk);
      check("clrwin_digits", Digits, 16'h0000);
      check("clrwin_error",  {15'd0, Error}, 16'd0);
      check("clrwin_valid",  {15'd0, TimeValid}, 16'd0);

      // 6. display scan
      enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd0);
      check("scan_digits", Digits, 16'h1230);
      check_scan("scan1230", 7'b1000000, 7'b0110000, 7'b0100100, 7'b1111001);
      clear_time();
      enter_digit(4'd4); enter_digit(4'd5);
      check("blank_digits", Digits, 16'h0045);
      check_scan("scan0045", 7'b0010010, 7'b0011001, 7'b1000000, 7'b1111111);

      // reset mid-entry restarts everything
      enter_digit(4'hB);
      @(negedge Clk); Rst = 1'b1;
      @(negedge Clk); Rst = 1'b0;
      check("rst2_digits", Digits, 16'h0000);
      check("rst2_error",  {15'd0, Error}, 16'd0);
      check("rst2_an_seg", {5'd0, An, Seg}, {5'd0, 4'b1110, 7'b1000000});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
